router_reg: RTL
===============

ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 Parameter DATA_W, default 8, byte width of packet data path.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 pkt_valid  input  1  source asserts while header/payload bytes are on data_in; deasserted with the parity byte.
REQ-005 data_in  input  DATA_W  packet byte from source.
REQ-006 fifo_full  input  1  selected destination FIFO full.
REQ-007 detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  one-hot state strobes from the router control FSM.
REQ-008 dout  output  DATA_W  registered byte to destination FIFO.
REQ-009 parity_done  output  1  parity byte of current packet captured.
REQ-010 low_pkt_valid  output  1  pkt_valid fell while FSM was in load-data.
REQ-011 err  output  1  parity mismatch for the completed packet.

Function
REQ-012 Header register SHALL capture data_in when detect_addr && pkt_valid; otherwise hold.
REQ-013 dout update priority: lfd_state -> header register; ld_state && !fifo_full -> data_in; laf_state -> hold register; otherwise hold value.
REQ-014 ld_state && fifo_full SHALL load data_in into the hold register and leave dout unchanged (byte not lost).
REQ-015 low_pkt_valid SHALL set on ld_state && !pkt_valid, clear on rst_int_reg (clear wins if both), else hold.
REQ-016 Parity-capture event P = (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done).
REQ-017 On P, packet-parity register SHALL load data_in (ld_state term) or hold register (laf_state term); parity_done SHALL set.
REQ-018 parity_done SHALL clear on detect_addr (priority over set), else hold.
REQ-019 Internal parity (XOR accumulator, DATA_W bits) SHALL clear on detect_addr.
REQ-020 Accumulator SHALL XOR in: header register on lfd_state; data_in on ld_state && pkt_valid && !fifo_full; hold register on laf_state && !low_pkt_valid; parity byte never included.
REQ-021 err SHALL load (internal parity != packet parity) on every cycle parity_done is 1 and detect_addr is 0; clear on detect_addr; else hold.
REQ-022 err therefore valid one cycle after parity_done rises and holds until next detect_addr.
REQ-023 full_state SHALL freeze dout, accumulator and hold register.
REQ-024 Latency: data_in to dout exactly one clock in ld_state; header appears on dout in the lfd_state cycle +1.
REQ-025 Simultaneous strobes (illegal from FSM) SHALL resolve by priority lfd_state > ld_state > laf_state; no X generation.
REQ-026 All widths exact DATA_W; no arithmetic other than XOR and equality.

Reset
REQ-027 rst=1 at a clock edge SHALL zero dout, parity_done, low_pkt_valid, err, header, hold, accumulator and packet-parity registers.
REQ-028 Reset SHALL override every other condition, including mid-packet; first post-reset packet behaves as from idle.
REQ-029 No output SHALL depend combinationally on inputs.

Verification
REQ-030 Reset: drive rst=1 two cycles with random inputs -> all outputs 0 on the following cycle.
REQ-031 Good packet: header 0x0D, payload 0x11,0x22,0x33, parity 0x0D, no full -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1; err=0 one cycle later.
REQ-032 Bad parity: same packet, parity byte 0x0E -> parity_done=1, err=1 next cycle, cleared at next detect_addr.
REQ-033 Full mid-payload: fifo_full=1 while 0x22 presented in ld_state -> dout stays 0x11; after laf_state dout=0x22; final err=0.
REQ-034 Parity byte arrives while full: ld_state && fifo_full && !pkt_valid with 0x0D -> low_pkt_valid=1; in laf_state packet parity=0x0D, parity_done=1, err=0; rst_int_reg clears low_pkt_valid.
REQ-035 Reset mid-packet after two payload bytes -> outputs zero; next good packet yields err=0.

Source files
------------

// File: rtl/router_reg.sv
// Router datapath register: header/hold/output byte registers plus running parity check.
// dout follows data_in one clock later in load-data; every output comes straight from a flop.
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_addr,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;

  logic ld_go;
  logic ld_stall;
  logic laf_go;
  logic par_from_ld;
  logic par_from_laf;
  logic par_evt;

  // Strobes are one-hot from the FSM; if several are ever seen together,
  // lfd outranks ld and ld outranks laf.
  assign ld_go    = ld_state && !lfd_state && !fifo_full;
  assign ld_stall = ld_state && !lfd_state && fifo_full;
  assign laf_go   = laf_state && !lfd_state && !ld_state;

  assign par_from_ld  = ld_state && !fifo_full && !pkt_valid;
  assign par_from_laf = laf_state && low_pkt_valid && !parity_done;
  assign par_evt      = par_from_ld || par_from_laf;

  always_ff @(posedge clk) begin
    if (rst) begin
      header <= '0;
    end else if (detect_addr && pkt_valid) begin
      header <= data_in;
    end
  end

  // full_state freezes the byte path and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      hold <= '0;
    end else if (!full_state) begin
      if (lfd_state) begin
        dout <= header;
      end else if (ld_go) begin
        dout <= data_in;
      end else if (laf_go) begin
        dout <= hold;
      end
      if (ld_stall) begin
        hold <= data_in;
      end
    end
  end

  // Parity byte is never folded in: ld term requires pkt_valid, laf term
  // requires that the byte in hold was payload (low_pkt_valid still clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      int_parity <= '0;
    end else if (!full_state) begin
      if (detect_addr) begin
        int_parity <= '0;
      end else if (lfd_state) begin
        int_parity <= int_parity ^ header;
      end else if (ld_go && pkt_valid) begin
        int_parity <= int_parity ^ data_in;
      end else if (laf_go && !low_pkt_valid) begin
        int_parity <= int_parity ^ hold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_parity  <= '0;
      parity_done <= 1'b0;
    end else begin
      if (par_evt) begin
        pkt_parity <= par_from_ld ? data_in : hold;
      end
      if (detect_addr) begin
        parity_done <= 1'b0;
      end else if (par_evt) begin
        parity_done <= 1'b1;
      end
    end
  end

  // Compare runs off registered values, so err settles one cycle after parity_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (detect_addr) begin
      err <= 1'b0;
    end else if (parity_done) begin
      err <= (int_parity != pkt_parity);
    end
  end

endmodule
